// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the multi-cycle control FSM and shift_sequencer.
// master: the controller, which drives start/op_in/op_type/op_amt and observes busy/done/result.
// slave: the sequencer, which observes the request and drives busy/done/result.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] op_in;
  logic [2:0]       op_type;
  logic [AMT_W-1:0] op_amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op_in, op_type, op_amt,
    input  busy, done, result
  );

  modport slave (
    input  start, op_in, op_type, op_amt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Purpose: runs an external 1-bit shifter op_amt times, feeding each output back in.
// Latency: done pulses op_amt+1 cycles after the accepting edge (1 cycle when op_amt==0).
// Backpressure: start is taken only in IDLE; requests while busy are dropped, never queued.
//
// Ports: clk, rst_n (synchronous, active-low); bus (shift_sequencer_if.slave) carries
// start/op_in/op_type/op_amt in and busy/done/result out; sh_in/sh_type drive the
// shifter, sh_out returns from it. Defining SHIFT_SEQ_CARRY_EN adds carry_out, the
// last bit shifted out of the accumulator, updated together with result.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]     sh_in,
  output logic [2:0]           sh_type,
  input  logic [WIDTH-1:0]     sh_out
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic                 carry_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       type_q, type_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
`ifdef SHIFT_SEQ_CARRY_EN
  logic             carry_q, carry_d;
  logic             carry_step;

  // Bit that the current step pushes out of acc: MSB for left shifts/rotates,
  // LSB for right ones; pass-through types shift nothing out.
  always_comb begin
    carry_step = 1'b0;
    case (type_q)
      3'd1, 3'd3:       carry_step = acc_q[WIDTH-1];
      3'd2, 3'd4, 3'd5: carry_step = acc_q[0];
      default:          carry_step = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
    carry_d  = carry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d  = bus.op_in;
          type_d = bus.op_type;
          cnt_d  = bus.op_amt;
          if (bus.op_amt == '0) begin
            // Zero-step request: the operand is the answer, skip SHIFT entirely.
            state_d  = S_DONE;
            result_d = bus.op_in;
            done_d   = 1'b1;
`ifdef SHIFT_SEQ_CARRY_EN
            carry_d  = 1'b0;
`endif
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = sh_out;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          // Last step: sh_out already holds the final value, so register it
          // as the result on the same edge that enters DONE.
          state_d  = S_DONE;
          result_d = sh_out;
          done_d   = 1'b1;
`ifdef SHIFT_SEQ_CARRY_EN
          carry_d  = carry_step;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      type_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q  <= carry_d;
`endif
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign sh_in      = acc_q;
  // Outside SHIFT the shifter is told to pass through, so it never sees a stale type.
  assign sh_type    = (state_q == S_SHIFT) ? type_q : 3'b000;
`ifdef SHIFT_SEQ_CARRY_EN
  assign carry_out  = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;
  localparam int MAXC  = 12;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sh_in;
  logic [2:0]       sh_type;
  logic [WIDTH-1:0] sh_out;
`ifdef SHIFT_SEQ_CARRY_EN
  logic             carry_out;
`endif

  int checks = 0;
  int errors = 0;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sh_in   (sh_in),
    .sh_type (sh_type),
    .sh_out  (sh_out)
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    .carry_out (carry_out)
`endif
  );

  // Reference 1-bit shifter living outside the sequencer.
  always_comb begin
    case (sh_type)
      3'd1:    sh_out = {sh_in[6:0], sh_in[7]};
      3'd2:    sh_out = {sh_in[0], sh_in[7:1]};
      3'd3:    sh_out = {sh_in[6:0], 1'b0};
      3'd4:    sh_out = {sh_in[7], sh_in[7:1]};
      3'd5:    sh_out = {1'b0, sh_in[7:1]};
      default: sh_out = sh_in;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [2:0] typ;
    logic [2:0] amt;
    logic [7:0] res;
    logic       cy;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Entered and left at a negedge; the start issued here is accepted at the next edge.
  task automatic run_op(input vec_t v, input int idx);
    int done_k;
    int busy_n;
    int type_err;
    logic [2:0] exp_t;
    done_k   = -1;
    busy_n   = 0;
    type_err = 0;
    bus.start   = 1'b1;
    bus.op_in   = v.op;
    bus.op_type = v.typ;
    bus.op_amt  = v.amt;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op_in   = ~v.op;
    bus.op_type = v.typ + 3'd1;
    bus.op_amt  = v.amt + 3'd2;
    check("sh_in_loaded", idx, 32'(sh_in), 32'(v.op));
    for (int k = 0; k < MAXC; k++) begin
      if (bus.busy) busy_n++;
      exp_t = (k < int'(v.amt)) ? v.typ : 3'd0;
      if (sh_type !== exp_t) type_err++;
      if (bus.done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check("done_latency", idx, 32'(done_k), 32'(v.amt));
    check("busy_cycles", idx, 32'(busy_n), 32'(v.amt) + 32'd1);
    check("sh_type_errs", idx, 32'(type_err), 32'd0);
    check("result", idx, 32'(bus.result), 32'(v.res));
`ifdef SHIFT_SEQ_CARRY_EN
    check("carry_out", idx, 32'(carry_out), 32'(v.cy));
`endif
    @(negedge clk);
    check("done_pulse_end", idx, 32'(bus.done), 32'd0);
    check("idle_after", idx, 32'(bus.busy), 32'd0);
    check("result_held", idx, 32'(bus.result), 32'(v.res));
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [7:0] res_seen;

    vecs[0] = '{op: 8'h81, typ: 3'd1, amt: 3'd1, res: 8'h03, cy: 1'b1};
    vecs[1] = '{op: 8'h81, typ: 3'd3, amt: 3'd3, res: 8'h08, cy: 1'b0};
    vecs[2] = '{op: 8'h80, typ: 3'd4, amt: 3'd7, res: 8'hFF, cy: 1'b0};
    vecs[3] = '{op: 8'hF0, typ: 3'd5, amt: 3'd4, res: 8'h0F, cy: 1'b0};
    vecs[4] = '{op: 8'h5A, typ: 3'd2, amt: 3'd0, res: 8'h5A, cy: 1'b0};
    vecs[5] = '{op: 8'hA5, typ: 3'd2, amt: 3'd3, res: 8'hB4, cy: 1'b1};
    vecs[6] = '{op: 8'h3C, typ: 3'd0, amt: 3'd5, res: 8'h3C, cy: 1'b0};
    vecs[7] = '{op: 8'h3C, typ: 3'd7, amt: 3'd2, res: 8'h3C, cy: 1'b0};
    vecs[8] = '{op: 8'h01, typ: 3'd5, amt: 3'd1, res: 8'h00, cy: 1'b1};
    vecs[9] = '{op: 8'hFF, typ: 3'd3, amt: 3'd7, res: 8'h80, cy: 1'b1};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op_in   = 8'h00;
    bus.op_type = 3'd0;
    bus.op_amt  = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 0, 32'(bus.busy), 32'd0);
    check("rst_done", 0, 32'(bus.done), 32'd0);
    check("rst_result", 0, 32'(bus.result), 32'd0);
    check("rst_sh_in", 0, 32'(sh_in), 32'd0);
    check("rst_sh_type", 0, 32'(sh_type), 32'd0);
`ifdef SHIFT_SEQ_CARRY_EN
    check("rst_carry", 0, 32'(carry_out), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table: each op starts in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // start pulsed with a different operand in the middle of a shift.
    done_cnt = 0;
    done_at  = -1;
    res_seen = 8'h00;
    bus.start   = 1'b1;
    bus.op_in   = 8'h81;
    bus.op_type = 3'd3;
    bus.op_amt  = 3'd3;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 1);
      if (k == 1) begin
        bus.op_in   = 8'h00;
        bus.op_type = 3'd0;
        bus.op_amt  = 3'd0;
      end
      if (bus.done) begin
        done_cnt++;
        done_at  = k;
        res_seen = bus.result;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_start_dones", 20, 32'(done_cnt), 32'd1);
    check("busy_start_when", 20, 32'(done_at), 32'd3);
    check("busy_start_result", 20, 32'(res_seen), 32'h08);

    // Reset in the second SHIFT cycle of a 5-step rotate.
    bus.start   = 1'b1;
    bus.op_in   = 8'h81;
    bus.op_type = 3'd1;
    bus.op_amt  = 3'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_busy_before", 21, 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 21, 32'(bus.busy), 32'd0);
    check("mid_rst_done", 21, 32'(bus.done), 32'd0);
    check("mid_rst_result", 21, 32'(bus.result), 32'd0);
    check("mid_rst_sh_in", 21, 32'(sh_in), 32'd0);
    check("mid_rst_sh_type", 21, 32'(sh_type), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 21, 32'(done_cnt), 32'd0);
    run_op(vecs[0], 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
